sparc_ex_unit: RTL and testbench

SPARC_EX_UNIT -- requirements
Module: sparc_ex_unit

---
 rtl/sparc_ex_pkg.sv | 45 ++++
 rtl/sparc_cond_eval.sv | 40 ++++
 rtl/sparc_ex_unit.sv | 95 +++++++++
 tb/tb_sparc_ex_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_ex_pkg.sv
// Shared encodings for the SPARC execute slice: ALU ops, Bicc conditions, flag bit positions.
// Optional macro ICC_BYPASS_EN is consumed by sparc_ex_unit.
package sparc_ex_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_ADDX  = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_SUBX  = 4'h3;
  localparam logic [3:0] OP_AND   = 4'h4;
  localparam logic [3:0] OP_ANDN  = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_ORN   = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_XNOR  = 4'h9;
  localparam logic [3:0] OP_SLL   = 4'hA;
  localparam logic [3:0] OP_SRL   = 4'hB;
  localparam logic [3:0] OP_SRA   = 4'hC;
  localparam logic [3:0] OP_PASSA = 4'hD;
  localparam logic [3:0] OP_PASSB = 4'hE;
  localparam logic [3:0] OP_ZERO  = 4'hF;

  localparam logic [3:0] COND_BN   = 4'h0;
  localparam logic [3:0] COND_BE   = 4'h1;
  localparam logic [3:0] COND_BLE  = 4'h2;
  localparam logic [3:0] COND_BL   = 4'h3;
  localparam logic [3:0] COND_BLEU = 4'h4;
  localparam logic [3:0] COND_BCS  = 4'h5;
  localparam logic [3:0] COND_BNEG = 4'h6;
  localparam logic [3:0] COND_BVS  = 4'h7;
  localparam logic [3:0] COND_BA   = 4'h8;
  localparam logic [3:0] COND_BNE  = 4'h9;
  localparam logic [3:0] COND_BG   = 4'hA;
  localparam logic [3:0] COND_BGE  = 4'hB;
  localparam logic [3:0] COND_BGU  = 4'hC;
  localparam logic [3:0] COND_BCC  = 4'hD;
  localparam logic [3:0] COND_BPOS = 4'hE;
  localparam logic [3:0] COND_BVC  = 4'hF;

  // Flag vectors are packed {N,Z,V,C}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/sparc_cond_eval.sv
// Bicc condition evaluator: maps a 4-bit cond field and {N,Z,V,C} flags to branch_taken.
module sparc_cond_eval
  import sparc_ex_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       branch_taken
);

  logic n, z, v, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  always_comb begin
    branch_taken = 1'b0;
    case (cond)
      COND_BA:   branch_taken = 1'b1;
      COND_BN:   branch_taken = 1'b0;
      COND_BNE:  branch_taken = ~z;
      COND_BE:   branch_taken = z;
      COND_BG:   branch_taken = ~(z | (n ^ v));
      COND_BLE:  branch_taken = z | (n ^ v);
      COND_BGE:  branch_taken = ~(n ^ v);
      COND_BL:   branch_taken = n ^ v;
      COND_BGU:  branch_taken = ~(c | z);
      COND_BLEU: branch_taken = c | z;
      COND_BCC:  branch_taken = ~c;
      COND_BCS:  branch_taken = c;
      COND_BPOS: branch_taken = ~n;
      COND_BNEG: branch_taken = n;
      COND_BVC:  branch_taken = ~v;
      COND_BVS:  branch_taken = v;
      default:   branch_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sparc_ex_unit.sv
// SPARC execute slice: combinational ALU, registered icc, branch/CALL target and Bicc evaluation.
// Define ICC_BYPASS_EN to let branches see this cycle's flags when set_cc is high.
module sparc_ex_unit
  import sparc_ex_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        set_cc,
  input  logic [31:0] pc,
  input  logic [21:0] disp22,
  input  logic [29:0] disp30,
  input  logic        is_call,
  input  logic [3:0]  cond,
  output logic [31:0] alu_out,
  output logic [3:0]  alu_flags,
  output logic [3:0]  icc,
  output logic [31:0] target,
  output logic        branch_taken
);

  logic [32:0] wide;
  logic [4:0]  sh;
  logic        carry_in;
  logic        flag_v;
  logic        flag_c;
  logic [31:0] disp_ext;
  logic [3:0]  sel_flags;

  assign sh       = b[4:0];
  // Extended ops always chain from the committed carry, never the in-flight one.
  assign carry_in = icc[FLAG_C];

  always_comb begin
    wide    = '0;
    alu_out = '0;
    flag_v  = 1'b0;
    flag_c  = 1'b0;
    case (alu_op)
      OP_ADD, OP_ADDX: begin
        wide    = {1'b0, a} + {1'b0, b} + {32'b0, (alu_op == OP_ADDX) & carry_in};
        alu_out = wide[31:0];
        flag_c  = wide[32];
        flag_v  = (a[31] == b[31]) && (alu_out[31] != a[31]);
      end
      OP_SUB, OP_SUBX: begin
        // Bit 32 of the 33-bit difference is the borrow out.
        wide    = {1'b0, a} - {1'b0, b} - {32'b0, (alu_op == OP_SUBX) & carry_in};
        alu_out = wide[31:0];
        flag_c  = wide[32];
        flag_v  = (a[31] != b[31]) && (alu_out[31] != a[31]);
      end
      OP_AND:   alu_out = a & b;
      OP_ANDN:  alu_out = a & ~b;
      OP_OR:    alu_out = a | b;
      OP_ORN:   alu_out = a | ~b;
      OP_XOR:   alu_out = a ^ b;
      OP_XNOR:  alu_out = ~(a ^ b);
      OP_SLL:   alu_out = a << sh;
      OP_SRL:   alu_out = a >> sh;
      OP_SRA:   alu_out = $signed(a) >>> sh;
      OP_PASSA: alu_out = a;
      OP_PASSB: alu_out = b;
      default:  alu_out = '0;
    endcase
  end

  assign alu_flags = {alu_out[31], (alu_out == 32'h0), flag_v, flag_c};

  always_ff @(posedge clk) begin
    if (reset) begin
      icc <= 4'b0000;
    end else if (set_cc) begin
      icc <= alu_flags;
    end
  end

  assign disp_ext = is_call ? {disp30, 2'b00} : {{8{disp22[21]}}, disp22, 2'b00};
  assign target   = pc + disp_ext;

`ifdef ICC_BYPASS_EN
  assign sel_flags = set_cc ? alu_flags : icc;
`else
  assign sel_flags = icc;
`endif

  sparc_cond_eval u_cond_eval (
    .cond         (cond),
    .flags        (sel_flags),
    .branch_taken (branch_taken)
  );

endmodule

// File: tb/tb_sparc_ex_unit.sv
// Self-checking bench for sparc_ex_unit: directed vector table, corner sequences, and
// randomized cycles against an arithmetic reference model.
module tb_sparc_ex_unit;
  import sparc_ex_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        set_cc;
  logic [31:0] pc;
  logic [21:0] disp22;
  logic [29:0] disp30;
  logic        is_call;
  logic [3:0]  cond;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  logic [3:0]  icc;
  logic [31:0] target;
  logic        branch_taken;

  int checks;
  int failures;

  sparc_ex_unit dut (
    .clk          (clk),
    .reset        (reset),
    .alu_op       (alu_op),
    .a            (a),
    .b            (b),
    .set_cc       (set_cc),
    .pc           (pc),
    .disp22       (disp22),
    .disp30       (disp30),
    .is_call      (is_call),
    .cond         (cond),
    .alu_out      (alu_out),
    .alu_flags    (alu_flags),
    .icc          (icc),
    .target       (target),
    .branch_taken (branch_taken)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                           input logic sc);
    alu_op = op;
    a      = va;
    b      = vb;
    set_cc = sc;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Reference ALU: unbounded integer arithmetic, flags derived from range checks.
  function automatic void model_alu(input logic [3:0] op, input logic [31:0] va,
                                    input logic [31:0] vb, input logic cin,
                                    output logic [31:0] r, output logic [3:0] fl);
    longint wide, sv, ci;
    logic [31:0] ones;
    int sh;
    logic v, c;
    ones = 32'hFFFFFFFF;
    sh   = int'(vb[4:0]);
    v    = 1'b0;
    c    = 1'b0;
    ci   = ((op == OP_ADDX) || (op == OP_SUBX)) ? longint'(cin) : 0;
    r    = 32'h0;
    case (op)
      OP_ADD, OP_ADDX: begin
        wide = longint'(va) + longint'(vb) + ci;
        r    = wide[31:0];
        c    = wide > 64'sd4294967295;
        sv   = longint'($signed(va)) + longint'($signed(vb)) + ci;
        v    = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      OP_SUB, OP_SUBX: begin
        wide = longint'(va) - longint'(vb) - ci;
        r    = wide[31:0];
        c    = wide < 0;
        sv   = longint'($signed(va)) - longint'($signed(vb)) - ci;
        v    = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      OP_AND:   r = va & vb;
      OP_ANDN:  r = va & ~vb;
      OP_OR:    r = va | vb;
      OP_ORN:   r = va | ~vb;
      OP_XOR:   r = va ^ vb;
      OP_XNOR:  r = ~(va ^ vb);
      OP_SLL:   r = va << sh;
      OP_SRL:   r = va >> sh;
      OP_SRA:   r = (va >> sh) | (va[31] ? ~(ones >> sh) : 32'h0);
      OP_PASSA: r = va;
      OP_PASSB: r = vb;
      default:  r = 32'h0;
    endcase
    fl = {r[31], (r == 32'h0), v, c};
  endfunction

  // Conditions 0..7 are the base tests; bit 3 inverts them.
  function automatic logic model_branch(input logic [3:0] cd, input logic [3:0] f);
    logic n, z, v, c;
    logic [7:0] base;
    {n, z, v, c} = f;
    base = {v, n, c, c | z, n ^ v, z | (n ^ v), z, 1'b0};
    return base[cd[2:0]] ^ cd[3];
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] vpc, input logic [21:0] d22,
                                               input logic [29:0] d30, input logic call);
    longint d, t;
    if (call) begin
      d = longint'(d30);
      if (d >= 64'sd536870912) d = d - 64'sd1073741824;
    end else begin
      d = longint'(d22);
      if (d >= 64'sd2097152) d = d - 64'sd4194304;
    end
    t = longint'(vpc) + d * 4;
    return t[31:0];
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      4:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  logic [3:0]  model_icc;
  logic [31:0] exp_r;
  logic [3:0]  exp_fl;
  logic [3:0]  f_sel;
  logic        exp_bt;

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{OP_ADD,   32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1010};
    vecs[1]  = '{OP_SRA,   32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 4'b1000};
    vecs[2]  = '{OP_SRL,   32'h80000000, 32'h0000001F, 32'h00000001, 4'b0000};
    vecs[3]  = '{OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0101};
    vecs[4]  = '{OP_SUB,   32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1001};
    vecs[5]  = '{OP_SUB,   32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0010};
    vecs[6]  = '{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b1000};
    vecs[7]  = '{OP_ANDN,  32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 4'b0000};
    vecs[8]  = '{OP_OR,    32'h00000000, 32'h00000000, 32'h00000000, 4'b0100};
    vecs[9]  = '{OP_ORN,   32'h00000000, 32'hFFFFFFFF, 32'h00000000, 4'b0100};
    vecs[10] = '{OP_XOR,   32'h12345678, 32'h12345678, 32'h00000000, 4'b0100};
    vecs[11] = '{OP_XNOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b1000};
    vecs[12] = '{OP_SLL,   32'h00000001, 32'h0000001F, 32'h80000000, 4'b1000};
    vecs[13] = '{OP_PASSA, 32'h00000000, 32'h00000005, 32'h00000000, 4'b0100};
    vecs[14] = '{OP_PASSB, 32'h00000000, 32'h00000005, 32'h00000005, 4'b0000};
    vecs[15] = '{OP_ZERO,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100};

    reset   = 1'b1;
    pc      = 32'h0;
    disp22  = 22'h0;
    disp30  = 30'h0;
    is_call = 1'b0;
    cond    = COND_BA;
    drive_alu(OP_ADD, 32'h0, 32'h0, 1'b0);
    after_edge();
    after_edge();
    reset = 1'b0;
    #2;
    check("reset_icc", {28'h0, icc}, 32'h0);

    // Condition sanity with icc cleared.
    cond = COND_BA;  #1; check("icc0_ba",  {31'h0, branch_taken}, 32'h1);
    cond = COND_BN;  #1; check("icc0_bn",  {31'h0, branch_taken}, 32'h0);
    cond = COND_BE;  #1; check("icc0_be",  {31'h0, branch_taken}, 32'h0);
    cond = COND_BNE; #1; check("icc0_bne", {31'h0, branch_taken}, 32'h1);

    // Vector table; icc.C is 0 throughout so set_cc stays low.
    for (int i = 0; i < 16; i++) begin
      drive_alu(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0);
      #2;
      check($sformatf("vec%0d_out", i), alu_out, vecs[i].r);
      check($sformatf("vec%0d_flags", i), {28'h0, alu_flags}, {28'h0, vecs[i].fl});
    end

    // Target boundary cases.
    pc = 32'h1000; disp22 = 22'h3FFFFF; is_call = 1'b0; #2;
    check("target_bicc_neg", target, 32'h00000FFC);
    pc = 32'h0; disp30 = 30'h1; is_call = 1'b1; #2;
    check("target_call", target, 32'h4);
    pc = 32'hFFFFFFFC; disp30 = 30'h1; is_call = 1'b1; #2;
    check("target_wrap", target, 32'h0);

    // Equal SUB latches Z; BE then taken.
    after_edge();
    drive_alu(OP_SUB, 32'h5, 32'h5, 1'b1);
    cond = COND_BE;
`ifndef ICC_BYPASS_EN
    #2;
    check("be_same_cycle_no_bypass", {31'h0, branch_taken}, 32'h0);
`endif
    after_edge();
    set_cc = 1'b0;
    #2;
    check("icc_after_sub_eq", {28'h0, icc}, 32'h4);
    check("be_after_latch", {31'h0, branch_taken}, 32'h1);

    // Borrow chain: SUB 0-1 sets C, then ADDX 0+0 consumes it.
    after_edge();
    drive_alu(OP_SUB, 32'h0, 32'h1, 1'b1);
    #2;
    check("sub_borrow_out", alu_out, 32'hFFFFFFFF);
    check("sub_borrow_c", {31'h0, alu_flags[FLAG_C]}, 32'h1);
    after_edge();
    drive_alu(OP_ADDX, 32'h0, 32'h0, 1'b0);
    #2;
    check("addx_carry_in", alu_out, 32'h1);
    drive_alu(OP_SUBX, 32'h5, 32'h2, 1'b0);
    #2;
    check("subx_borrow_in", alu_out, 32'h2);

    // Reset beats set_cc.
    after_edge();
    reset = 1'b1;
    drive_alu(OP_ADD, 32'h7FFFFFFF, 32'h1, 1'b1);
    after_edge();
    reset = 1'b0;
    set_cc = 1'b0;
    #2;
    check("reset_over_set_cc", {28'h0, icc}, 32'h0);

    // Randomized cycles against the reference model.
    model_icc = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      after_edge();
      check("rnd_icc", {28'h0, icc}, {28'h0, model_icc});
      reset   = ($urandom_range(0, 39) == 0);
      alu_op  = 4'($urandom_range(0, 15));
      a       = rand_word();
      b       = rand_word();
      set_cc  = 1'($urandom_range(0, 1));
      cond    = 4'($urandom_range(0, 15));
      pc      = $urandom;
      disp22  = 22'($urandom);
      disp30  = 30'($urandom);
      is_call = 1'($urandom_range(0, 1));
      #2;
      model_alu(alu_op, a, b, model_icc[FLAG_C], exp_r, exp_fl);
`ifdef ICC_BYPASS_EN
      f_sel = set_cc ? exp_fl : model_icc;
`else
      f_sel = model_icc;
`endif
      exp_bt = model_branch(cond, f_sel);
      check("rnd_out", alu_out, exp_r);
      check("rnd_flags", {28'h0, alu_flags}, {28'h0, exp_fl});
      check("rnd_target", target, model_target(pc, disp22, disp30, is_call));
      check("rnd_branch", {31'h0, branch_taken}, {31'h0, exp_bt});
      if (reset) model_icc = 4'b0000;
      else if (set_cc) model_icc = exp_fl;
    end
    after_edge();
    check("rnd_icc_final", {28'h0, icc}, {28'h0, model_icc});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
